// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide unit with a shared shift/add-subtract core.
// Writes its result straight into the register file through the write port.
module cpu_muldiv #(
   parameter int XLEN = 32,
   parameter int ITER = XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            done,
   output logic            writeen,
   output logic [4:0]      addrw,
   output logic [XLEN-1:0] writeint
);

   localparam int CW = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [2:0]      fn_q;
   logic [4:0]      rd_q;
   logic            sa_q, sb_q;
   logic [XLEN-1:0] b_q, hi_q, lo_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q, done_q, we_q;
   logic [4:0]      addrw_q;
   logic [XLEN-1:0] wdata_q;

   logic            a_sgn, b_sgn, sa_d, sb_d;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum, div_sh, div_diff;
   logic [XLEN-1:0] hi_d, lo_d;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0] q_fix, r_fix, res_d;

   // Operand signedness by op: MULH/MULHSU/DIV/REM sign A, MULH/DIV/REM sign B
   always_comb begin
      a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b110);
      b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) ||
              (funct3 == 3'b110);
      sa_d  = a_sgn & rs1_val[XLEN-1];
      sb_d  = b_sgn & rs2_val[XLEN-1];
      mag_a = sa_d ? (~rs1_val + 1'b1) : rs1_val;
      mag_b = sb_d ? (~rs2_val + 1'b1) : rs2_val;
   end

   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_sh   = {hi_q, lo_q[XLEN-1]};
      div_diff = div_sh - {1'b0, b_q};
      hi_d     = hi_q;
      lo_d     = lo_q;
      if (!fn_q[2]) begin
         hi_d = mul_sum[XLEN:1];
         lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
         hi_d = div_diff[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
         hi_d = div_sh[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
   end

   // Sign fix; a zero divisor forces an all-ones quotient with no negation
   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;
      if (b_q == '0)
         q_fix = '1;
      else
         q_fix = (sa_q ^ sb_q) ? (~lo_q + 1'b1) : lo_q;
      r_fix = sa_q ? (~hi_q + 1'b1) : hi_q;
      case (fn_q)
         3'b000:         res_d = prod_fix[XLEN-1:0];
         3'b100, 3'b101: res_d = q_fix;
         3'b110, 3'b111: res_d = r_fix;
         default:        res_d = prod_fix[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         fn_q    <= '0;
         rd_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addrw_q <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  fn_q    <= funct3;
                  rd_q    <= rd_addr;
                  sa_q    <= sa_d;
                  sb_q    <= sb_d;
                  b_q     <= mag_b;
                  hi_q    <= '0;
                  lo_q    <= mag_a;
                  cnt_q   <= CW'(ITER);
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (cnt_q != '0) begin
                  hi_q  <= hi_d;
                  lo_q  <= lo_d;
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  wdata_q <= res_d;
                  done_q  <= 1'b1;
                  we_q    <= (rd_q != 5'd0);
                  addrw_q <= rd_q;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               we_q    <= 1'b0;
               addrw_q <= '0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign writeen  = we_q;
   assign addrw    = addrw_q;
   assign writeint = wdata_q;

endmodule

// File: tb/tb_cpu_muldiv.sv
// Directed and random checks of cpu_muldiv against an arithmetic model of RV32M.
// Tracks latency, write-port behaviour, start-while-busy and async reset.
module tb_cpu_muldiv;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val;
   logic [4:0]  rd_addr;
   logic        busy, done, writeen;
   logic [4:0]  addrw;
   logic [31:0] writeint;

   int n_assert = 0;
   int n_fail   = 0;
   int wr_seen  = 0;
   int wr_exp   = 0;

   always #5 clk = ~clk;

   cpu_muldiv #(.XLEN(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
      .busy(busy), .done(done), .writeen(writeen),
      .addrw(addrw), .writeint(writeint)
   );

   always @(negedge clk) if (writeen) wr_seen++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] sp [6];
      sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
             32'h7FFF_FFFF, 32'hFFFF_FFF9};
      if ($urandom_range(3) == 0) return sp[$urandom_range(5)];
      return $urandom;
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp,
                         input bit hammer);
      bit early;
      @(negedge clk);
      start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_addr = rd;
      @(posedge clk); #1;
      if (!hammer) start = 1'b0;
      rs1_val = $urandom; rs2_val = $urandom; funct3 = 3'($urandom);
      rd_addr = 5'($urandom);
      chk({tag, "_busy"}, {31'b0, busy}, 1);
      early = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         if (done || writeen || !busy) early = 1'b1;
         if (hammer) begin
            rs1_val = $urandom; rs2_val = $urandom;
            funct3 = 3'($urandom); rd_addr = 5'($urandom);
         end
      end
      chk({tag, "_early"}, {31'b0, early}, 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_done"}, {31'b0, done}, 1);
      chk({tag, "_we"}, {31'b0, writeen}, {31'b0, rd != 5'd0});
      chk({tag, "_addrw"}, {27'b0, addrw}, {27'b0, rd});
      chk({tag, "_data"}, writeint, exp);
      if (rd != 5'd0) wr_exp++;
      @(posedge clk); #1;
      chk({tag, "_idle"}, {29'b0, busy, done, writeen}, 0);
      chk({tag, "_hold"}, writeint, exp);
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      rst = 1'b1; start = 1'b0; funct3 = '0;
      rs1_val = '0; rs2_val = '0; rd_addr = '0;
      #1;
      chk("rst_ctl", {29'b0, busy, done, writeen}, 0);
      chk("rst_addrw", {27'b0, addrw}, 0);
      chk("rst_data", writeint, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
      run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 0);
      run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 0);
      run_op("mulhsu", 3'd2, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'hC000_0000, 0);
      run_op("div0", 3'd4, 32'hFFFF_FFF9, 32'd0, 5'd9, 32'hFFFF_FFFF, 0);
      run_op("divu0", 3'd5, 32'hFFFF_FFF9, 32'd0, 5'd10, 32'hFFFF_FFFF, 0);
      run_op("rem0", 3'd6, 32'hFFFF_FFF9, 32'd0, 5'd11, 32'hFFFF_FFF9, 0);
      run_op("remu0", 3'd7, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFF9, 0);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 0);
      run_op("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFD, 0);
      run_op("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFF, 0);
      run_op("rd0", 3'd5, 32'd100, 32'd3, 5'd0, 32'd33, 0);
      run_op("hammer", 3'd0, 32'd12345, 32'd678, 5'd17, 32'd8369910, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("no_queue", {31'b0, busy}, 0);

      // Async reset in the middle of an operation
      @(negedge clk);
      start = 1'b1; funct3 = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd7;
      rd_addr = 5'd20;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_ctl", {29'b0, busy, done, writeen}, 0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("arst_idle", {31'b0, busy}, 0);
      run_op("post_rst", 3'd5, 32'd1000, 32'd7, 5'd21, 32'd142, 0);

      for (int i = 0; i < 40; i++) begin
         f  = 3'($urandom);
         a  = pick();
         b  = pick();
         rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
         run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, rd, model(f, a, b), 0);
      end

      #1;
      chk("write_count", 32'(wr_seen), 32'(wr_exp));
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
